// File: rtl/dcl_readout_serializer_if.sv
// Write port from the DCL packet generator into the readout FIFO,
// plus the occupancy flags returned to the DCL.
interface dcl_readout_serializer_if #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 54
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [PKT_W-1:0] packet;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  modport master (output push, packet, input fifo_full, fifo_empty, fifo_count);
  modport slave  (input push, packet, output fifo_full, fifo_empty, fifo_count);
endinterface

// File: rtl/dcl_readout_serializer.sv
// DCL readout serializer: packet FIFO, frame builder ({start, chip_id, packet})
// and MSB-first serial shifter gated by ser_en, with drop accounting.
module dcl_readout_serializer #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 54,
  parameter int ID_W  = 5,
  parameter int GAP   = 2
)(
  input  logic                     clock,
  input  logic                     rst_b,
  dcl_readout_serializer_if.slave  dcl,
  input  logic [ID_W-1:0]          chip_id,
  input  logic                     ser_en,
  input  logic                     clr_drop,
  output logic                     ser_out,
  output logic                     ser_busy,
  output logic                     frame_done,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int F  = 1 + ID_W + PKT_W;
  localparam int BW = $clog2(F);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             wr, load;
  state_t           state, nxt;
  logic [F-1:0]     sh;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  // Flags come straight off the registered occupancy, never from push.
  assign dcl.fifo_full  = (count == CW'(DEPTH));
  assign dcl.fifo_empty = (count == '0);
  assign dcl.fifo_count = count;

  assign wr = dcl.push && !dcl.fifo_full;
  // A frame loads from IDLE, or directly at the end of the gap so that
  // back-to-back frames are separated by exactly GAP idle bits.
  assign load = ser_en && !dcl.fifo_empty &&
                ((state == S_IDLE) || (state == S_GAP && gap_cnt == '0));

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= dcl.packet;

  // Pointers and occupancy; a pop only ever happens on a frame load.
  always_ff @(posedge clock or negedge rst_b)
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)   wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(load);
    end

  // Saturating drop counter; a clear wins over a coincident drop.
  always_ff @(posedge clock or negedge rst_b)
    if (!rst_b)                                              drop_count <= '0;
    else if (clr_drop)                                       drop_count <= '0;
    else if (dcl.push && dcl.fifo_full && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

  // State register.
  always_ff @(posedge clock or negedge rst_b)
    if (!rst_b) state <= S_IDLE;
    else        state <= nxt;

  // Next-state logic; everything advances only on ser_en.
  always_comb begin
    nxt = state;
    if (ser_en)
      case (state)
        S_IDLE:  if (!dcl.fifo_empty) nxt = S_SHIFT;
        S_SHIFT: if (bit_cnt == '0)   nxt = S_GAP;
        S_GAP:   if (gap_cnt == '0)   nxt = dcl.fifo_empty ? S_IDLE : S_SHIFT;
        default: nxt = S_IDLE;
      endcase
  end

  // Shift register, bit/gap counters and the single-clock frame_done pulse.
  // chip_id is captured at load so later changes do not touch the frame.
  always_ff @(posedge clock or negedge rst_b)
    if (!rst_b) begin
      sh         <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ser_en && (state == S_SHIFT) && (bit_cnt == BW'(1));
      if (load) begin
        sh      <= {1'b1, chip_id, mem[rd_ptr]};
        bit_cnt <= BW'(F - 1);
      end else if (ser_en && state == S_SHIFT) begin
        if (bit_cnt != '0) begin
          sh      <= sh << 1;
          bit_cnt <= bit_cnt - BW'(1);
        end else begin
          gap_cnt <= GW'(GAP - 1);
        end
      end else if (ser_en && state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end

  // Outputs decoded from state so reset forces the line low at once.
  always_comb begin
    ser_out  = (state == S_SHIFT) && sh[F-1];
    ser_busy = (state != S_IDLE);
  end
endmodule

// File: tb/tb_dcl_readout_serializer.sv
`timescale 1ns/1ps
// Directed bench for dcl_readout_serializer.
module tb_dcl_readout_serializer;
  localparam int DEPTH = 4, PKT_W = 54, ID_W = 5, GAP = 2, F = 60, FG = F + GAP;

  logic            clock = 1'b0, rst_b = 1'b0;
  logic [ID_W-1:0] chip_id = '0;
  logic            ser_en = 1'b0, clr_drop = 1'b0;
  logic            ser_out, ser_busy, frame_done;
  logic [7:0]      drop_count;
  int              total = 0, bad = 0, cyc = 0;
  bit              throttle = 1'b0;
  logic            so [1024];
  logic            fd [1024];

  dcl_readout_serializer_if #(.DEPTH(DEPTH), .PKT_W(PKT_W)) bus ();

  dcl_readout_serializer #(.DEPTH(DEPTH), .PKT_W(PKT_W), .ID_W(ID_W), .GAP(GAP)) dut (
    .clock(clock), .rst_b(rst_b), .dcl(bus), .chip_id(chip_id), .ser_en(ser_en),
    .clr_drop(clr_drop), .ser_out(ser_out), .ser_busy(ser_busy),
    .frame_done(frame_done), .drop_count(drop_count)
  );

  always #12.5 clock = ~clock;

  function automatic logic [F-1:0] frm(input logic [ID_W-1:0] id, input logic [PKT_W-1:0] p);
    return {1'b1, id, p};
  endfunction

  task automatic tick();
    @(posedge clock); #1;
    cyc++;
    if (throttle) ser_en = (cyc % 4 == 0);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; bus.push = 1'b0; bus.packet = '0;
    tick(); tick();
    total++; if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    total++; if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0) begin bad++; $display("FAIL reset_flags: got e=%b f=%b want e=1 f=0", bus.fifo_empty, bus.fifo_full); end
    total++; if ({ser_out, ser_busy, frame_done} !== 3'b000) begin bad++; $display("FAIL reset_ser: got %b want 000", {ser_out, ser_busy, frame_done}); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [PKT_W-1:0] p;
    logic [F-1:0] e;
    logic exp_b;
    int err, fderr;
    p = 54'h2A_5A_3C_00000001;
    chip_id = 5'h13; ser_en = 1'b1;
    e = frm(5'h13, p);
    bus.push = 1'b1; bus.packet = p;
    tick();
    bus.push = 1'b0;
    total++; if (bus.fifo_count !== 3'd1 || ser_out !== 1'b0) begin bad++; $display("FAIL single_after_push: got cnt=%0d so=%b want cnt=1 so=0", bus.fifo_count, ser_out); end
    tick();
    total++; if (bus.fifo_count !== 3'd0 || ser_out !== 1'b1 || ser_busy !== 1'b1) begin bad++; $display("FAIL single_load: got cnt=%0d so=%b busy=%b want 0 1 1", bus.fifo_count, ser_out, ser_busy); end
    err = 0; fderr = 0;
    for (int j = 0; j < FG; j++) begin
      exp_b = (j < F) ? e[F-1-j] : 1'b0;
      if (ser_out !== exp_b) err++;
      if (frame_done !== (j == F - 1)) fderr++;
      if (j == 10) chip_id = 5'h0C;
      tick();
    end
    total++; if (err != 0) begin bad++; $display("FAIL single_bits: got %0d bad bits want 0", err); end
    total++; if (fderr != 0) begin bad++; $display("FAIL single_frame_done: got %0d bad cycles want 0", fderr); end
    total++; if (ser_busy !== 1'b0 || ser_out !== 1'b0) begin bad++; $display("FAIL single_idle: got busy=%b so=%b want 0 0", ser_busy, ser_out); end
  endtask

  task automatic test_back_to_back();
    logic [PKT_W-1:0] pk [4];
    logic [F-1:0] e;
    logic exp_b;
    bit full_seen;
    int err;
    pk[0] = 54'h3F_0000_1234_5678; pk[1] = 54'h00_1111_2222_3333;
    pk[2] = 54'h15_5555_5555_5555; pk[3] = 54'h2A_AAAA_AAAA_AAAA;
    chip_id = 5'h0A; ser_en = 1'b1; full_seen = 1'b0;
    for (int c = 0; c < 252; c++) begin
      bus.push = (c < 4); bus.packet = pk[c % 4];
      tick();
      if (bus.fifo_full) full_seen = 1'b1;
      so[c] = ser_out; fd[c] = frame_done;
    end
    bus.push = 1'b0;
    total++; if (full_seen) begin bad++; $display("FAIL b2b_full: got full=1 want never"); end
    for (int k = 0; k < 4; k++) begin
      e = frm(5'h0A, pk[k]); err = 0;
      for (int j = 0; j < FG; j++) begin
        exp_b = (j < F) ? e[F-1-j] : 1'b0;
        if (so[1 + FG*k + j] !== exp_b) err++;
        if (fd[1 + FG*k + j] !== (j == F - 1)) err++;
      end
      total++; if (err != 0) begin bad++; $display("FAIL b2b_frame%0d: got %0d bad cycles want 0", k, err); end
    end
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL b2b_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_overflow();
    logic [PKT_W-1:0] pk [6];
    logic [F-1:0] e;
    logic exp_b;
    int err;
    pk[0] = 54'h01_0203_0405_0607; pk[1] = 54'h3C_C3C3_C3C3_C3C3;
    pk[2] = 54'h2A_5A_3C_00000001; pk[3] = 54'h00_0000_0000_0001;
    pk[4] = 54'h3F_FFFF_FFFF_FFFF; pk[5] = 54'h12_3456_789A_BCDE;
    chip_id = 5'h15; ser_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.push = 1'b1; bus.packet = pk[c];
      tick();
      if (c == 3) begin
        total++; if (bus.fifo_full !== 1'b1 || bus.fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_full: got f=%b cnt=%0d want 1 4", bus.fifo_full, bus.fifo_count); end
      end
    end
    bus.push = 1'b0;
    total++; if (drop_count !== 8'd2 || bus.fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_drop: got drop=%0d cnt=%0d want 2 4", drop_count, bus.fifo_count); end
    ser_en = 1'b1;
    for (int c = 0; c < 250; c++) begin
      tick();
      so[c] = ser_out; fd[c] = frame_done;
    end
    for (int k = 0; k < 4; k++) begin
      e = frm(5'h15, pk[k]); err = 0;
      for (int j = 0; j < FG; j++) begin
        exp_b = (j < F) ? e[F-1-j] : 1'b0;
        if (so[FG*k + j] !== exp_b) err++;
      end
      total++; if (err != 0) begin bad++; $display("FAIL ovf_frame%0d: got %0d bad bits want 0", k, err); end
    end
    total++; if (bus.fifo_empty !== 1'b1 || ser_busy !== 1'b0) begin bad++; $display("FAIL ovf_drain: got e=%b busy=%b want 1 0", bus.fifo_empty, ser_busy); end
  endtask

  task automatic test_throttle();
    logic [PKT_W-1:0] p;
    logic [F-1:0] e;
    int s, err, nfd;
    p = 54'h2D_0F0F_00FF_1357;
    chip_id = 5'h07; throttle = 1'b1;
    e = frm(5'h07, p);
    for (int c = 0; c < 300; c++) begin
      bus.push = (c == 0); bus.packet = p;
      tick();
      so[c] = ser_out; fd[c] = frame_done;
    end
    bus.push = 1'b0; throttle = 1'b0; ser_en = 1'b1;
    s = -1;
    for (int c = 0; c < 10; c++) if (s < 0 && so[c] === 1'b1) s = c;
    total++;
    if (s < 0) begin
      bad++; $display("FAIL thr_start: got no start bit in 10 clocks want start");
    end else begin
      err = 0; nfd = 0;
      for (int j = 0; j < F; j++)
        for (int h = 0; h < 4; h++)
          if (so[s + 4*j + h] !== e[F-1-j]) err++;
      for (int h = 0; h < 8; h++) if (so[s + 240 + h] !== 1'b0) err++;
      for (int c = 0; c < 300; c++) if (fd[c] === 1'b1) nfd++;
      if (err != 0) begin bad++; $display("FAIL thr_bits: got %0d bad clocks want 0", err); end
      total++; if (nfd != 1 || fd[s + 236] !== 1'b1) begin bad++; $display("FAIL thr_frame_done: got %0d pulses at_last=%b want 1 1", nfd, fd[s + 236]); end
    end
  endtask

  task automatic test_saturation();
    ser_en = 1'b0;
    for (int c = 0; c < 4; c++) begin bus.push = 1'b1; bus.packet = 54'(c); tick(); end
    bus.push = 1'b0; clr_drop = 1'b1; tick(); clr_drop = 1'b0;
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", drop_count); end
    bus.push = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (c == 199) begin
        total++; if (drop_count !== 8'd200) begin bad++; $display("FAIL sat_mid: got %0d want 200", drop_count); end
      end
    end
    total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_cap: got %0d want 255", drop_count); end
    clr_drop = 1'b1; tick(); clr_drop = 1'b0; bus.push = 1'b0;
    total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL sat_clr_vs_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_reset_midframe();
    logic [PKT_W-1:0] p;
    logic [F-1:0] e;
    bit activity;
    p = 54'h15_5555_5555_5555;
    rst_b = 1'b0; tick(); rst_b = 1'b1;
    chip_id = 5'h19; ser_en = 1'b1;
    e = frm(5'h19, p);
    for (int c = 0; c < 22; c++) begin
      bus.push = (c < 3); bus.packet = p;
      tick();
    end
    bus.push = 1'b0;
    total++; if (bus.fifo_count !== 3'd2 || ser_out !== e[F-1-20]) begin bad++; $display("FAIL rst_bit20: got cnt=%0d so=%b want 2 %b", bus.fifo_count, ser_out, e[F-1-20]); end
    rst_b = 1'b0; #1;
    total++; if (ser_out !== 1'b0 || ser_busy !== 1'b0 || bus.fifo_count !== 3'd0 || bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_async: got so=%b busy=%b cnt=%0d e=%b want 0 0 0 1", ser_out, ser_busy, bus.fifo_count, bus.fifo_empty); end
    tick(); rst_b = 1'b1;
    activity = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (ser_out !== 1'b0 || ser_busy !== 1'b0) activity = 1'b1;
    end
    total++; if (activity) begin bad++; $display("FAIL rst_quiet: got activity=1 want 0"); end
    bus.push = 1'b1; bus.packet = p; tick(); bus.push = 1'b0; tick();
    total++; if (ser_out !== 1'b1 || bus.fifo_count !== 3'd0) begin bad++; $display("FAIL rst_new_frame: got so=%b cnt=%0d want 1 0", ser_out, bus.fifo_count); end
  endtask

  initial begin
    bus.push = 1'b0; bus.packet = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_throttle();
    test_saturation();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
